// File: rtl/oled_iic_sequencer_if.sv
// -----------------------------------------------------------------------------
// oled_iic_sequencer_if
// Control and handshake bundle between oled_iic_sequencer and iic_master.
//   send_en        : start one transaction (held until send_busy is seen)
//   slave_addr_ex  : extended (10-bit) addressing select, always 0 here
//   slave_addr     : 7-bit address already shifted into bits [7:1]
//   send_rw        : 0 = write
//   reg_addr       : I2C control byte sent after the address byte
//   send_data      : current burst byte
//   brust_vaild    : more bytes follow the byte currently on the wire
//   brust_ready    : master has taken the current byte (SCL domain)
//   send_busy      : master transaction in progress (SCL domain)
// Modports: master = sequencer side, slave = iic_master side.
// -----------------------------------------------------------------------------
interface oled_iic_sequencer_if;
    logic        send_en;
    logic        slave_addr_ex;
    logic [15:0] slave_addr;
    logic        send_rw;
    logic [7:0]  reg_addr;
    logic [7:0]  send_data;
    logic        brust_vaild;
    logic        brust_ready;
    logic        send_busy;

    modport master (
        output send_en, slave_addr_ex, slave_addr, send_rw,
               reg_addr, send_data, brust_vaild,
        input  brust_ready, send_busy
    );

    modport slave (
        input  send_en, slave_addr_ex, slave_addr, send_rw,
               reg_addr, send_data, brust_vaild,
        output brust_ready, send_busy
    );
endinterface

// File: rtl/oled_iic_sequencer.sv
// -----------------------------------------------------------------------------
// oled_iic_sequencer
// Drives iic_master for an SSD1306 128x64 OLED at 0x3C: power-up wait, one
// 25-byte init command burst, then on request a 6-byte window command burst
// followed by a 1024-byte GDDRAM burst fetched from an external framebuffer.
//
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   frame_req    : level, request one refresh (sampled only in IDLE)
//   init_done    : high after the init burst, until reset
//   frame_busy   : high from refresh start to refresh end
//   frame_done   : 1-cycle pulse at refresh end
//   fb_addr      : framebuffer read address (page*128 + column)
//   fb_data      : framebuffer read data, 1-cycle synchronous latency
//   iic          : oled_iic_sequencer_if.master towards iic_master
//
// Configuration macro: OLED_AUTO_REFRESH_EN
//   defined   -> IDLE always starts a new refresh (frame_req unused)
//   undefined -> refresh only on frame_req
// -----------------------------------------------------------------------------
module oled_iic_sequencer #(
    parameter int CLK_FRE    = 50,
    parameter int PWR_DLY_US = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_req,
    output logic                        init_done,
    output logic                        frame_busy,
    output logic                        frame_done,
    output logic [9:0]                  fb_addr,
    input  logic [7:0]                  fb_data,
    oled_iic_sequencer_if.master        iic
);
    localparam int                PWR_CYC   = CLK_FRE * PWR_DLY_US;
    localparam int                PWR_W     = $clog2(PWR_CYC + 1);
    localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(PWR_CYC);
    localparam logic [9:0]        INIT_LAST = 10'd24;
    localparam logic [9:0]        WIN_LAST  = 10'd5;
    localparam logic [9:0]        DATA_LAST = 10'd1023;
    localparam logic [7:0]        CTRL_CMD  = 8'h00;
    localparam logic [7:0]        CTRL_DATA = 8'h40;

    typedef enum logic [2:0] {S_PWR, S_INIT, S_WAIT, S_IDLE, S_WIN, S_DATA} state_t;
    typedef enum logic [1:0] {RET_INIT, RET_WIN, RET_DATA} ret_t;

    function automatic logic [7:0] init_byte(input logic [9:0] idx);
        logic [7:0] b;
        case (idx)
            10'd0:  b = 8'hAE;  10'd1:  b = 8'hD5;  10'd2:  b = 8'h80;
            10'd3:  b = 8'hA8;  10'd4:  b = 8'h3F;  10'd5:  b = 8'hD3;
            10'd6:  b = 8'h00;  10'd7:  b = 8'h40;  10'd8:  b = 8'h8D;
            10'd9:  b = 8'h14;  10'd10: b = 8'h20;  10'd11: b = 8'h00;
            10'd12: b = 8'hA1;  10'd13: b = 8'hC8;  10'd14: b = 8'hDA;
            10'd15: b = 8'h12;  10'd16: b = 8'h81;  10'd17: b = 8'hCF;
            10'd18: b = 8'hD9;  10'd19: b = 8'hF1;  10'd20: b = 8'hDB;
            10'd21: b = 8'h40;  10'd22: b = 8'hA4;  10'd23: b = 8'hA6;
            10'd24: b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Column range 0..127, page range 0..7.
    function automatic logic [7:0] win_byte(input logic [9:0] idx);
        logic [7:0] b;
        case (idx)
            10'd0: b = 8'h21;  10'd1: b = 8'h00;  10'd2: b = 8'h7F;
            10'd3: b = 8'h22;  10'd4: b = 8'h00;  10'd5: b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ---------------- SCL-domain input synchronisers ----------------
    logic [1:0] br_sync, busy_sync;
    logic       br_q;
    logic       busy_s, br_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            br_sync   <= '0;
            busy_sync <= '0;
            br_q      <= 1'b0;
        end else begin
            br_sync   <= {br_sync[0], iic.brust_ready};
            busy_sync <= {busy_sync[0], iic.send_busy};
            br_q      <= br_sync[1];
        end
    end

    assign busy_s  = busy_sync[1];
    assign br_rise = br_sync[1] & ~br_q;

    // ---------------- request source ----------------
    logic req;
`ifdef OLED_AUTO_REFRESH_EN
    assign req = 1'b1;
`else
    assign req = frame_req;
`endif

    // ---------------- FSM ----------------
    state_t           state, state_n;
    ret_t             ret, ret_n;
    logic [9:0]       cnt, cnt_n, last_idx;
    logic [PWR_W-1:0] pwr_cnt, pwr_cnt_n;
    logic             send_en_q, send_en_n;
    logic             vaild_q, vaild_n;
    logic [7:0]       data_q, data_n;
    logic [7:0]       reg_addr_q, reg_addr_n;
    logic             init_done_n, frame_busy_n, frame_done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_PWR;
            ret        <= RET_INIT;
            cnt        <= '0;
            pwr_cnt    <= '0;
            send_en_q  <= 1'b0;
            vaild_q    <= 1'b0;
            data_q     <= 8'h00;
            reg_addr_q <= 8'h00;
            init_done  <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            cnt        <= cnt_n;
            pwr_cnt    <= pwr_cnt_n;
            send_en_q  <= send_en_n;
            vaild_q    <= vaild_n;
            data_q     <= data_n;
            reg_addr_q <= reg_addr_n;
            init_done  <= init_done_n;
            frame_busy <= frame_busy_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n      = state;
        ret_n        = ret;
        cnt_n        = cnt;
        pwr_cnt_n    = pwr_cnt;
        send_en_n    = send_en_q;
        vaild_n      = vaild_q;
        data_n       = data_q;
        reg_addr_n   = reg_addr_q;
        init_done_n  = init_done;
        frame_busy_n = frame_busy;
        frame_done_n = 1'b0;
        last_idx     = INIT_LAST;

        // iic_master samples send_en only on scl_x2 edges; hold it until busy.
        if (send_en_q && busy_s)
            send_en_n = 1'b0;

        unique case (state)
            S_PWR: begin
                if (pwr_cnt != PWR_LAST) begin
                    pwr_cnt_n = pwr_cnt + 1'b1;
                end else if (!busy_s) begin
                    // Busy check keeps a transfer cut short by reset from overlapping.
                    state_n    = S_INIT;
                    cnt_n      = '0;
                    send_en_n  = 1'b1;
                    vaild_n    = 1'b1;
                    reg_addr_n = CTRL_CMD;
                    data_n     = init_byte(10'd0);
                end
            end

            S_INIT, S_WIN, S_DATA: begin
                if (state == S_INIT)     last_idx = INIT_LAST;
                else if (state == S_WIN) last_idx = WIN_LAST;
                else                     last_idx = DATA_LAST;

                if (br_rise) begin
                    if (vaild_q) begin
                        cnt_n   = cnt + 10'd1;
                        vaild_n = (cnt_n != last_idx);
                        if (state == S_INIT)     data_n = init_byte(cnt_n);
                        else if (state == S_WIN) data_n = win_byte(cnt_n);
                    end else begin
                        state_n = S_WAIT;
                        // Parking cnt at 0 pre-fetches fb[0] before DATA starts.
                        cnt_n   = '0;
                        if (state == S_INIT)     ret_n = RET_INIT;
                        else if (state == S_WIN) ret_n = RET_WIN;
                        else                     ret_n = RET_DATA;
                    end
                end
                // fb_addr follows cnt; RAM data lands one cycle later and is
                // registered here, giving the second cycle of update latency.
                if (state == S_DATA)
                    data_n = fb_data;
            end

            S_WAIT: begin
                if (!busy_s) begin
                    unique case (ret)
                        RET_INIT: begin
                            init_done_n = 1'b1;
                            state_n     = S_IDLE;
                        end
                        RET_WIN: begin
                            state_n    = S_DATA;
                            cnt_n      = '0;
                            send_en_n  = 1'b1;
                            vaild_n    = 1'b1;
                            reg_addr_n = CTRL_DATA;
                            data_n     = fb_data;
                        end
                        default: begin
                            frame_done_n = 1'b1;
                            frame_busy_n = 1'b0;
                            state_n      = S_IDLE;
                        end
                    endcase
                end
            end

            S_IDLE: begin
                if (req) begin
                    state_n      = S_WIN;
                    frame_busy_n = 1'b1;
                    cnt_n        = '0;
                    send_en_n    = 1'b1;
                    vaild_n      = 1'b1;
                    reg_addr_n   = CTRL_CMD;
                    data_n       = win_byte(10'd0);
                end
            end

            default: state_n = S_PWR;
        endcase
    end

    // ---------------- outputs ----------------
    assign fb_addr           = cnt;
    assign iic.send_en       = send_en_q;
    assign iic.slave_addr_ex = 1'b0;
    assign iic.slave_addr    = 16'h0078;
    assign iic.send_rw       = 1'b0;
    assign iic.reg_addr      = reg_addr_q;
    assign iic.send_data     = data_q;
    assign iic.brust_vaild   = vaild_q;
endmodule

// File: tb/tb_oled_iic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_oled_iic_sequencer
// Bench for oled_iic_sequencer with a transaction-level iic_master model that
// logs every byte it would put on the wire, a framebuffer RAM model, and a
// reference built from the SSD1306 command lists and framebuffer contents.
// -----------------------------------------------------------------------------
module tb_oled_iic_sequencer;
    localparam int CLK_FRE    = 50;
    localparam int PWR_DLY_US = 10;
    localparam int PWR_CYC    = CLK_FRE * PWR_DLY_US;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_req;
    logic       init_done, frame_busy, frame_done;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    oled_iic_sequencer_if bus ();

    oled_iic_sequencer #(.CLK_FRE(CLK_FRE), .PWR_DLY_US(PWR_DLY_US)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_req (frame_req),
        .init_done (init_done),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .iic       (bus)
    );

    always #5 clk = ~clk;

    // ---------------- framebuffer RAM and reference copy ----------------
    logic [7:0] fb_mem [1024];
    logic [7:0] fb_ref [1024];
    always @(posedge clk) fb_data <= fb_mem[fb_addr];

    // ---------------- bookkeeping ----------------
    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- iic_master transaction model ----------------
    int         tick_div    = 6;   // clk cycles per scl_x2 edge
    int         busy_hold   = 0;   // extra cycles busy stays high after STOP
    int         tx_done_cnt = 0;
    logic [7:0] byte_log [$];
    int         tx_start [$];
    int         tx_len   [$];

    task automatic wait_ticks(input int n);
        repeat (n * tick_div) @(negedge clk);
    endtask

    initial begin : bus_model
        logic more;
        int   st;
        bus.brust_ready = 1'b0;
        bus.send_busy   = 1'b0;
        forever begin
            wait_ticks(1);
            if (bus.send_en === 1'b1) begin
                bus.send_busy = 1'b1;
                st = byte_log.size();
                tx_start.push_back(st);
                byte_log.push_back(bus.slave_addr[7:0] | {7'd0, bus.send_rw});
                wait_ticks(2);
                byte_log.push_back(bus.reg_addr);
                wait_ticks(2);
                more = 1'b1;
                while (more) begin
                    byte_log.push_back(bus.send_data);       // byte captured
                    wait_ticks(2);
                    bus.brust_ready = 1'b1;
                    more = bus.brust_vaild && (byte_log.size() - st < 1100);
                    wait_ticks(2);
                    bus.brust_ready = 1'b0;
                end
                wait_ticks(2);                               // STOP condition
                if (busy_hold > 0) begin
                    repeat (busy_hold) @(negedge clk);
                    busy_hold = 0;
                end
                tx_len.push_back(byte_log.size() - st);
                bus.send_busy = 1'b0;
                tx_done_cnt++;
            end
        end
    end

    // ---------------- expectation table for command bursts ----------------
    typedef struct {
        string      name;
        int         kind;   // 0 = init transaction, 1 = window transaction
        int         idx;    // byte position within the transaction
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [$];

    task automatic add_row(input string name, input int kind, input int idx, input logic [7:0] exp);
        vec_t v;
        v.name = name; v.kind = kind; v.idx = idx; v.exp = exp;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] log_byte(input int tx, input int idx);
        int pos;
        if (tx >= tx_start.size()) return 32'hdead_beef;
        pos = tx_start[tx] + idx;
        if (pos >= byte_log.size()) return 32'hdead_beef;
        return {24'd0, byte_log[pos]};
    endfunction

    task automatic apply_table(input int kind, input int tx, input int exp_len);
        check($sformatf("tx%0d length", tx), (tx < tx_len.size()) ? tx_len[tx] : -1, exp_len);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].kind == kind)
                check($sformatf("tx%0d %s", tx, tbl[i].name), log_byte(tx, tbl[i].idx), {24'd0, tbl[i].exp});
    endtask

    // Reference for a GDDRAM burst: horizontal addressing walks page by page,
    // column by column over the framebuffer.
    task automatic check_data_tx(input int tx, input int n_bytes, input string name);
        int k = 0;
        check({name, " addr"}, log_byte(tx, 0), 32'h78);
        check({name, " ctrl"}, log_byte(tx, 1), 32'h40);
        for (int page = 0; page < 8; page++)
            for (int col = 0; col < 128; col++) begin
                if (k < n_bytes)
                    check($sformatf("%s p%0d c%0d", name, page, col),
                          log_byte(tx, 2 + k), {24'd0, fb_ref[page*128 + col]});
                k++;
            end
    endtask

    // ---------------- bounded waits ----------------
    task automatic wait_tx(input int n, input int budget, input string name);
        int c = 0;
        while (tx_done_cnt < n && c < budget) begin @(negedge clk); c++; end
        check(name, tx_done_cnt >= n, 1);
    endtask

    task automatic wait_init_done(input string name);
        int c = 0;
        while (!init_done && c < 20) begin @(negedge clk); c++; end
        check(name, init_done, 1);
    endtask

    task automatic wait_frame_done(input int budget, output bit seen, output bit busy_prev, output int cyc);
        cyc = 0;
        busy_prev = frame_busy;
        while (!frame_done && cyc < budget) begin
            busy_prev = frame_busy;
            @(negedge clk);
            cyc++;
        end
        seen = frame_done;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " send_en"},     bus.send_en,     0);
        check({tag, " brust_vaild"}, bus.brust_vaild, 0);
        check({tag, " send_data"},   bus.send_data,   0);
        check({tag, " reg_addr"},    bus.reg_addr,    0);
        check({tag, " fb_addr"},     fb_addr,         0);
        check({tag, " init_done"},   init_done,       0);
        check({tag, " frame_busy"},  frame_busy,      0);
        check({tag, " frame_done"},  frame_done,      0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] init_list [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                                       8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                                       8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB,
                                       8'h40, 8'hA4, 8'hA6, 8'hAF};
        logic [7:0] win_list [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        int  c, fall, quiet_bad;
        bit  seen, busy_prev;
        int  gap;

        add_row("addr", 0, 0, 8'h78);
        add_row("ctrl", 0, 1, 8'h00);
        for (int i = 0; i < 25; i++) add_row($sformatf("init[%0d]", i), 0, 2 + i, init_list[i]);
        add_row("addr", 1, 0, 8'h78);
        add_row("ctrl", 1, 1, 8'h00);
        for (int i = 0; i < 6; i++) add_row($sformatf("win[%0d]", i), 1, 2 + i, win_list[i]);

        for (int i = 0; i < 1024; i++) begin
            fb_mem[i] = i[7:0];
            fb_ref[i] = i[7:0];
        end

        rst_n = 1'b0;
        frame_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Power-up delay: nothing moves until the count expires.
        rst_n = 1'b1;
        c = 0;
        quiet_bad = 0;
        while (!bus.send_en && c < 2000) begin
            @(negedge clk);
            c++;
            if (!bus.send_en && (bus.brust_vaild || bus.send_data != 0 || bus.reg_addr != 0 ||
                                 fb_addr != 0 || init_done || frame_busy || frame_done))
                quiet_bad++;
        end
        check("outputs quiet during power-up", quiet_bad, 0);
        check("send_en rise 500..502 cycles", (c >= PWR_CYC) && (c <= PWR_CYC + 2), 1);

        // Init burst.
        wait_tx(1, 5000, "init transaction completes");
        wait_init_done("init_done after init STOP");
        apply_table(0, 0, 27);

`ifdef OLED_AUTO_REFRESH_EN
        // Continuous refresh with frame_req low.
        wait_frame_done(40000, seen, busy_prev, c);
        check("auto frame 1 done", seen, 1);
        @(negedge clk);
        wait_frame_done(40000, seen, busy_prev, gap);
        check("auto frame 2 done", seen, 1);
        check("auto frame spacing", (gap > 1024 * 4 * 6) && (gap < 40000), 1);
        apply_table(1, 1, 8);
        check_data_tx(2, 1024, "auto data");
`else
        // Frame 1: fb[i] = i, extra request during DATA must be ignored.
        frame_req = 1'b1;
        @(negedge clk);
        check("frame_busy rises on WIN entry", frame_busy, 1);
        frame_req = 1'b0;

        c = 0;
        while (!(tx_start.size() >= 3 && byte_log.size() - tx_start[2] >= 100) && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check("DATA burst reached byte 98", c < 20000, 1);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;

        wait_frame_done(40000, seen, busy_prev, c);
        check("frame_done pulse seen", seen, 1);
        check("frame_busy low with frame_done", frame_busy, 0);
        check("frame_busy high before frame_done", busy_prev, 1);

        gap = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_done) gap++;
        end
        check("no extra frame_done", gap, 0);
        check("no queued frame", tx_start.size(), 3);
        check("idle after frame", frame_busy, 0);

        apply_table(1, 1, 8);
        check("data tx length", (tx_len.size() > 2) ? tx_len[2] : -1, 1026);
        check_data_tx(2, 1024, "data");

        // Frame 2: random framebuffer, reset at DATA byte 300.
        tick_div = $urandom_range(6, 9);
        for (int i = 0; i < 1024; i++) begin
            fb_mem[i] = 8'($urandom);
            fb_ref[i] = fb_mem[i];
        end
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        c = 0;
        while (!(tx_start.size() >= 5 && byte_log.size() - tx_start[4] >= 302) && c < 40000) begin
            @(negedge clk);
            c++;
        end
        check("random DATA reached byte 300", c < 40000, 1);

        busy_hold = 700;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-DATA reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        c = 0;
        fall = -1;
        while (!bus.send_en && c < 5000) begin
            @(negedge clk);
            c++;
            if (fall < 0 && !bus.send_busy) fall = c;
        end
        check("send_en after reset seen", bus.send_en, 1);
        check("busy low when send_en rises", bus.send_busy, 0);
        check("PWR waits for busy low", (fall >= 0) && (c - fall >= 1) && (c - fall <= 4), 1);
        check("partial tx stopped after byte", (tx_len.size() > 4) ? tx_len[4] : -1, 302);
        check_data_tx(4, 300, "rand data");

        wait_tx(6, 8000, "re-init transaction completes");
        wait_init_done("init_done after re-init");
        apply_table(0, 5, 27);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
